// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with N combinational read ports, one
// write port, write-to-read bypass and a per-register busy scoreboard.
// Optional feature: define REG_ZERO_EN to hardwire register 0 to zero
// (reads 0, never busy, writes ignored, issue to r0 always ready).
module reg_file_sb #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_FILE_SIZE = 32,
    parameter int NUM_RD_PORTS  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_busy,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               iss_en,
    input  logic [ADDR_WIDTH-1:0]              iss_addr,
    output logic                               iss_ready,
    output logic [$clog2(REG_FILE_SIZE+1)-1:0] busy_count
);

    // Index width actually needed to address the array; upper address bits
    // only matter for the range check.
    localparam int IW = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
    localparam int CW = $clog2(REG_FILE_SIZE+1);

`ifdef REG_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]    regs_q [REG_FILE_SIZE];
    logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(REG_FILE_SIZE);
    endfunction

    function automatic logic is_z(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_EN && (a == '0);
    endfunction

    logic          wr_hit, iss_set, iss_clr;
    logic [IW-1:0] wi, ii;

    assign wi     = wr_addr[IW-1:0];
    assign ii     = iss_addr[IW-1:0];
    // A write that actually lands in the array (in range, not the zero register).
    assign wr_hit = wr_en && in_rng(wr_addr) && !is_z(wr_addr);

    // Read ports: out of range -> 0, same-cycle write -> bypass, else array.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] pdata;
        logic                  pbusy;

        assign ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Per-port operand select with bypass and busy lookup.
        always_comb begin
            pdata = '0;
            pbusy = 1'b0;
            if (in_rng(ra) && !is_z(ra)) begin
                if (wr_en && (wr_addr == ra)) begin
                    pdata = wr_data;
                end else begin
                    pdata = regs_q[ra[IW-1:0]];
                    pbusy = busy_q[ra[IW-1:0]];
                end
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = pdata;
        assign rd_busy[p]                          = pbusy;
    end

    // Issue acceptance: destination free, or being freed by this cycle's write.
    always_comb begin
        iss_ready = 1'b0;
        if (in_rng(iss_addr)) begin
            if (is_z(iss_addr)) iss_ready = 1'b1;
            else                iss_ready = !busy_q[ii] || (wr_en && (wr_addr == iss_addr));
        end
    end

    assign iss_set = iss_en && iss_ready && !is_z(iss_addr);
    assign iss_clr = wr_hit && busy_q[wi];

    // Scoreboard next state: write clears, accepted issue sets (set wins on a tie).
    always_comb begin
        busy_d = busy_q;
        if (wr_hit)  busy_d[wi] = 1'b0;
        if (iss_set) busy_d[ii] = 1'b1;
    end

    // Busy counter tracks set/clear events; a same-register set+clear nets to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (iss_set && !iss_clr && (cnt_q != CW'(REG_FILE_SIZE))) cnt_d = cnt_q + 1'b1;
        else if (!iss_set && iss_clr && (cnt_q != '0))             cnt_d = cnt_q - 1'b1;
    end

    // State registers; reset wipes data and drops every in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_hit) regs_q[wi] <= wr_data;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_count = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb (ADDR_WIDTH=6, 32 regs, 4 read ports).
module tb_reg_file_sb;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NP = 4;
`ifdef REG_ZERO_EN
    localparam bit ZE = 1'b1;
`else
    localparam bit ZE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             iss_ready;
    logic [5:0]       busy_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_FILE_SIZE(32), .NUM_RD_PORTS(NP)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready), .busy_count(busy_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rdd(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        #3;
        chk("rst_cnt",   64'(busy_count), 64'd0);
        chk("rst_data",  64'(rd_data != '0), 64'd0);
        chk("rst_busy",  64'(rd_busy), 64'd0);
        chk("rst_ready", 64'(iss_ready), 64'd1);
        #4 rst = 1'b0;
        tick;

        // async reset mid-run
        wr_en = 1; wr_addr = 3; wr_data = 32'h33; iss_en = 1; iss_addr = 9;
        tick;
        wr_addr = 7; wr_data = 32'h77; iss_en = 0;
        tick;
        wr_en = 0; set_rd(0, 3); set_rd(1, 7); set_rd(2, 9);
        #1;
        chk("pre_r3",  64'(rdd(0)), 64'h33);
        chk("pre_r7",  64'(rdd(1)), 64'h77);
        chk("pre_b9",  64'(rd_busy[2]), 64'd1);
        chk("pre_cnt", 64'(busy_count), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_r3",   64'(rdd(0)), 64'd0);
        chk("arst_r7",   64'(rdd(1)), 64'd0);
        chk("arst_busy", 64'(rd_busy), 64'd0);
        chk("arst_cnt",  64'(busy_count), 64'd0);
        #1 rst = 1'b0;
        tick;

        // write bypass, then array read
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(0, 5);
        #1;
        chk("byp_r5",  64'(rdd(0)), 64'hDEADBEEF);
        chk("byp_b5",  64'(rd_busy[0]), 64'd0);
        tick;
        wr_en = 0;
        #1;
        chk("arr_r5",  64'(rdd(0)), 64'hDEADBEEF);

        // issue, WAW hold-off, write + reissue same cycle
        iss_en = 1; iss_addr = 4;
        #1 chk("iss4_rdy", 64'(iss_ready), 64'd1);
        tick;
        iss_en = 0; set_rd(0, 4);
        #1;
        chk("r4_busy",  64'(rd_busy[0]), 64'd1);
        chk("r4_cnt",   64'(busy_count), 64'd1);
        chk("waw_rdy",  64'(iss_ready), 64'd0);
        iss_en = 1;
        tick;
        chk("waw_cnt",  64'(busy_count), 64'd1);
        wr_en = 1; wr_addr = 4; wr_data = 32'h12;
        #1;
        chk("wi_rdy",   64'(iss_ready), 64'd1);
        chk("wi_byp",   64'(rdd(0)), 64'h12);
        chk("wi_bbyp",  64'(rd_busy[0]), 64'd0);
        tick;
        wr_en = 0; iss_en = 0;
        #1;
        chk("wi_busy",  64'(rd_busy[0]), 64'd1);
        chk("wi_cnt",   64'(busy_count), 64'd1);
        chk("wi_data",  64'(rdd(0)), 64'h12);
        wr_en = 1;
        tick;
        wr_en = 0;
        #1;
        chk("r4_clr_cnt",  64'(busy_count), 64'd0);
        chk("r4_clr_busy", 64'(rd_busy[0]), 64'd0);

        // fill scoreboard, saturate, drain
        for (int i = 1; i < 32; i++) begin
            iss_en = 1; iss_addr = AW'(i);
            tick;
        end
        iss_en = 0;
        #1 chk("fill_cnt", 64'(busy_count), 64'd31);
        iss_en = 1; iss_addr = 0;
        tick;
        iss_en = 0;
        #1 chk("fill_r0_cnt", 64'(busy_count), ZE ? 64'd31 : 64'd32);
        iss_addr = 5;
        #1 chk("full_rdy", 64'(iss_ready), 64'd0);
        iss_en = 1;
        tick;
        iss_en = 0;
        #1 chk("full_cnt", 64'(busy_count), ZE ? 64'd31 : 64'd32);
        for (int i = 0; i < 32; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = 32'h1000 + 32'(i);
            tick;
        end
        wr_en = 0; set_rd(0, 8);
        #1;
        chk("drain_cnt", 64'(busy_count), 64'd0);
        chk("drain_r8",  64'(rdd(0)), 64'h1008);

        // out-of-range address 40
        set_rd(1, 40); iss_addr = 40; wr_en = 1; wr_addr = 40; wr_data = 32'hBAD;
        #1;
        chk("oor_data", 64'(rdd(1)), 64'd0);
        chk("oor_busy", 64'(rd_busy[1]), 64'd0);
        chk("oor_rdy",  64'(iss_ready), 64'd0);
        tick;
        wr_en = 0;
        #1;
        chk("oor_alias_r8", 64'(rdd(0)), 64'h1008);

        // register 0
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; set_rd(0, 0);
        #1 chk("r0_byp", 64'(rdd(0)), ZE ? 64'd0 : 64'hFFFFFFFF);
        tick;
        wr_en = 0; iss_en = 1; iss_addr = 0;
        tick;
        iss_en = 0;
        #1;
        chk("r0_data", 64'(rdd(0)), ZE ? 64'd0 : 64'hFFFFFFFF);
        chk("r0_busy", 64'(rd_busy[0]), ZE ? 64'd0 : 64'd1);
        chk("r0_cnt",  64'(busy_count), ZE ? 64'd0 : 64'd1);
        wr_en = 1; wr_addr = 0; wr_data = 0;
        tick;
        wr_en = 0;

        // four ports, write hits port 2 only
        iss_en = 1; iss_addr = 10;
        tick;
        iss_addr = 11;
        tick;
        iss_en = 0; wr_en = 1; wr_addr = 12; wr_data = 32'hC;
        tick;
        wr_addr = 13; wr_data = 32'hD;
        tick;
        set_rd(0, 10); set_rd(1, 12); set_rd(2, 11); set_rd(3, 13);
        wr_addr = 11; wr_data = 32'hB11;
        #1;
        chk("mp_p0", 64'(rdd(0)), 64'h100A);
        chk("mp_p1", 64'(rdd(1)), 64'hC);
        chk("mp_p2", 64'(rdd(2)), 64'hB11);
        chk("mp_p3", 64'(rdd(3)), 64'hD);
        chk("mp_busy", 64'(rd_busy), 64'b0001);
        tick;
        wr_en = 0;
        #1 chk("mp_cnt", 64'(busy_count), 64'd1);

        // issue + write same reg: busy visible only next cycle
        wr_en = 1; wr_addr = 12; wr_data = 32'hCC; iss_en = 1; iss_addr = 12;
        #1 chk("iw_busy_now", 64'(rd_busy[1]), 64'd0);
        tick;
        wr_en = 0; iss_en = 0;
        #1;
        chk("iw_busy_nxt", 64'(rd_busy[1]), 64'd1);
        chk("iw_cnt",      64'(busy_count), 64'd2);
        chk("iw_data",     64'(rdd(1)), 64'hCC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
